evb_fsm3: RTL and testbench

EVB_FSM3 -- requirements
Module: evb_fsm3

---
 rtl/evb_fsm3_if.sv | 46 ++++
 rtl/evb_fsm3.sv | 189 ++++++++++++++++++
 tb/tb_evb_fsm3.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evb_fsm3_if.sv
`default_nettype none
// ============================================================================
// Module      : evb_fsm3_if
// Description : Instruction, memory-read and result bundle of the EVB
//               polynomial-evaluation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface evb_fsm3_if #(
    parameter int AW        = 10,
    parameter int WORD_SIZE = 16
);
    logic                 start_evb;
    logic [2:0]           A;
    logic [4:0]           b;
    logic [WORD_SIZE-1:0] x_b;
    logic [WORD_SIZE-1:0] c_i;
    logic [4:0]           N;
    logic [AW-1:0]        rd_addr_data;

    logic                 done_evp;
    logic                 done_evb;
    logic                 en_rd_data;
    logic                 en_rd_S;
    logic                 en_rd_N;
    logic [AW-1:0]        rd_addr_data_updated;
    logic [AW-1:0]        rd_addr_x;
    logic [6:0]           rd_addr_S;
    logic [2:0]           rd_addr_N;
    logic [31:0]          result;
    logic [31:0]          status;

    modport master (
        input  start_evb, A, b, x_b, c_i, N, rd_addr_data,
        output done_evp, done_evb, en_rd_data, en_rd_S, en_rd_N,
               rd_addr_data_updated, rd_addr_x, rd_addr_S, rd_addr_N,
               result, status
    );

    modport slave (
        output start_evb, A, b, x_b, c_i, N, rd_addr_data,
        input  done_evp, done_evb, en_rd_data, en_rd_S, en_rd_N,
               rd_addr_data_updated, rd_addr_x, rd_addr_S, rd_addr_N,
               result, status
    );
endinterface
`default_nettype wire

// File: rtl/evb_fsm3.sv
`default_nettype none
// ============================================================================
// Module      : evb_fsm3
// Description : EVB sequencer - Horner evaluation of polynomial A at b points.
//               Optional build macro: EVB_OVERFLOW_DETECT_EN (status bit1).
// Revision    : 1.0 - initial release
// ============================================================================
module evb_fsm3 #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  rst_instr,
    evb_fsm3_if.master bus
);
    localparam int       AW        = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam logic [4:0] c_MAX_DEG = 5'd10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_EN_EVB    = 4'd1,
        S_P_RD_N    = 4'd2,
        S_P_CHECK_N = 4'd3,
        S_P_RD_X    = 4'd4,
        S_P_RD_C    = 4'd5,
        S_P_MAC     = 4'd6,
        S_P_ERROR   = 4'd7,
        S_P_DONE    = 4'd8,
        S_CHECK_B   = 4'd9,
        S_END       = 4'd10
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           a_q, a_d;
    logic [4:0]           b_q, b_d;
    logic [4:0]           k_q, k_d;
    logic [3:0]           i_q, i_d;
    logic [AW-1:0]        base_q, base_d;
    logic [AW-1:0]        upd_q, upd_d;
    logic [word_size-1:0] x_q, x_d;
    logic [31:0]          acc_q, acc_d;
    logic [31:0]          result_q, result_d;
    logic [1:0]           st_q, st_d;

    logic [31:0]          w_mac;
    logic                 w_pt_ovf;

`ifdef EVB_OVERFLOW_DETECT_EN
    // Full-width Horner step; any bit above 31 means the wrapped value lost information.
    localparam int c_MW = 33 + word_size;
    logic [c_MW-1:0] w_mac_full;
    logic            w_step_ovf;
    logic            ovf_q;

    assign w_mac_full = c_MW'(acc_q) * c_MW'(x_q) + c_MW'(bus.c_i);
    assign w_mac      = w_mac_full[31:0];
    assign w_step_ovf = |w_mac_full[c_MW-1:32];
    assign w_pt_ovf   = ovf_q | w_step_ovf;

    always_ff @(posedge clk) begin
        if (rst || rst_instr || state_q == S_P_CHECK_N) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_P_MAC) begin
            ovf_q <= w_pt_ovf;
        end
    end
`else
    assign w_mac    = acc_q * 32'(x_q) + 32'(bus.c_i);
    assign w_pt_ovf = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        i_d      = i_q;
        base_d   = base_q;
        upd_d    = upd_q;
        x_d      = x_q;
        acc_d    = acc_q;
        result_d = result_q;
        st_d     = st_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_evb) state_d = S_EN_EVB;
            end
            S_EN_EVB: begin
                a_d    = bus.A;
                b_d    = bus.b;
                base_d = bus.rd_addr_data;
                k_d    = 5'd0;
                if (bus.b == 5'd0) begin
                    upd_d   = bus.rd_addr_data;
                    state_d = S_END;
                end else begin
                    state_d = S_P_RD_N;
                end
            end
            S_P_RD_N:    state_d = S_P_CHECK_N;
            S_P_CHECK_N: begin
                // The undefined marker 31 also falls in the out-of-range degree test.
                if (bus.N > c_MAX_DEG) begin
                    state_d = S_P_ERROR;
                end else begin
                    i_d     = bus.N[3:0];
                    acc_d   = 32'd0;
                    state_d = S_P_RD_X;
                end
            end
            S_P_RD_X:    state_d = S_P_RD_C;
            S_P_RD_C: begin
                x_d     = bus.x_b;
                state_d = S_P_MAC;
            end
            S_P_MAC: begin
                acc_d = w_mac;
                if (i_q == 4'd0) begin
                    result_d = w_mac;
                    st_d     = {w_pt_ovf, 1'b0};
                    state_d  = S_P_DONE;
                end else begin
                    i_d     = i_q - 4'd1;
                    state_d = S_P_RD_C;
                end
            end
            S_P_ERROR: begin
                result_d = 32'd0;
                st_d     = 2'b01;
                state_d  = S_P_DONE;
            end
            S_P_DONE:    state_d = S_CHECK_B;
            S_CHECK_B: begin
                k_d = k_q + 5'd1;
                if (k_q + 5'd1 == b_q) begin
                    upd_d   = base_q + AW'(b_q);
                    state_d = S_END;
                end else begin
                    state_d = S_P_RD_N;
                end
            end
            S_END:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rst_instr) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            i_q      <= '0;
            base_q   <= '0;
            upd_q    <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            st_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            i_q      <= i_d;
            base_q   <= base_d;
            upd_q    <= upd_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            st_q     <= st_d;
        end
    end

    assign bus.en_rd_N              = (state_q == S_P_RD_N);
    assign bus.en_rd_data           = (state_q == S_P_RD_X);
    assign bus.en_rd_S              = (state_q == S_P_RD_C);
    assign bus.done_evp             = (state_q == S_P_DONE);
    assign bus.done_evb             = (state_q == S_END);
    assign bus.rd_addr_N            = a_q;
    assign bus.rd_addr_S            = ({4'd0, a_q} * 7'd11) + {3'd0, i_q};
    assign bus.rd_addr_x            = base_q + AW'(k_q);
    assign bus.rd_addr_data_updated = upd_q;
    assign bus.result               = result_q;
    assign bus.status               = {30'd0, st_q};

endmodule
`default_nettype wire

// File: tb/tb_evb_fsm3.sv
`default_nettype none
// ============================================================================
// Module      : tb_evb_fsm3
// Description : Directed self-checking bench for evb_fsm3 with N/S/data models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evb_fsm3;
    logic clk = 1'b0;
    logic rst;
    logic rst_instr;
    always #5 clk = ~clk;

    evb_fsm3_if #(.AW(10), .WORD_SIZE(16)) bus ();

    evb_fsm3 #(.word_size(16), .buffer_size(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_instr (rst_instr),
        .bus       (bus)
    );

    logic [4:0]  nmem [8];
    logic [15:0] smem [128];
    logic [15:0] dmem [1024];

    // Memory models: registered read data, updated only on their enable.
    always @(posedge clk) begin
        if (rst) begin
            bus.N   <= '0;
            bus.c_i <= '0;
            bus.x_b <= '0;
        end else begin
            if (bus.en_rd_N)    bus.N   <= nmem[bus.rd_addr_N];
            if (bus.en_rd_S)    bus.c_i <= smem[bus.rd_addr_S];
            if (bus.en_rd_data) bus.x_b <= dmem[bus.rd_addr_x];
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] obs_res[$];
    logic [31:0] obs_st[$];
    bit          evb_seen, en_seen, tmo;
    int          evb_lat;
    logic [9:0]  evb_addr;

    task automatic start_instr(input logic [2:0] a, input logic [4:0] bb, input logic [9:0] base);
        @(negedge clk);
        bus.A            = a;
        bus.b            = bb;
        bus.rd_addr_data = base;
        bus.start_evb    = 1'b1;
        @(negedge clk);
        bus.start_evb    = 1'b0;
    endtask

    task automatic collect();
        obs_res.delete();
        obs_st.delete();
        evb_seen = 1'b0;
        en_seen  = 1'b0;
        tmo      = 1'b1;
        evb_lat  = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (bus.en_rd_N || bus.en_rd_S || bus.en_rd_data) en_seen = 1'b1;
            if (bus.done_evp) begin
                obs_res.push_back(bus.result);
                obs_st.push_back(bus.status);
            end
            if (bus.done_evb) begin
                evb_seen = 1'b1;
                evb_addr = bus.rd_addr_data_updated;
                evb_lat  = c + 1;
                tmo      = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.done_evp, bus.done_evb, bus.en_rd_N, bus.en_rd_S, bus.en_rd_data} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.done_evp, bus.done_evb, bus.en_rd_N, bus.en_rd_S, bus.en_rd_data});
        end
        n_checks++;
        if (bus.result !== 32'd0) begin
            n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result);
        end
        n_checks++;
        if (bus.status !== 32'd0) begin
            n_fail++; $display("FAIL reset_status: got %0d expected 0", bus.status);
        end
        n_checks++;
        if (bus.rd_addr_data_updated !== 10'd0) begin
            n_fail++; $display("FAIL reset_addr_upd: got %0d expected 0", bus.rd_addr_data_updated);
        end
    endtask

    task automatic test_undefined();
        start_instr(3'd5, 5'd3, 10'd0);
        collect();
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL undef_timeout: done_evb missing, expected within bound"); end
        n_checks++;
        if (obs_res.size() !== 3) begin n_fail++; $display("FAIL undef_count: got %0d expected 3", obs_res.size()); end
        for (int i = 0; i < obs_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== 32'd0 || obs_st[i] !== 32'd1) begin
                n_fail++;
                $display("FAIL undef_pt%0d: got result %0d status %0d expected 0/1", i, obs_res[i], obs_st[i]);
            end
        end
        n_checks++;
        if (evb_addr !== 10'd3) begin n_fail++; $display("FAIL undef_addr_upd: got %0d expected 3", evb_addr); end
    endtask

    task automatic test_horner();
        logic [31:0] exp_r [3];
        exp_r = '{32'd10, 32'd27, 32'd60};
        start_instr(3'd0, 5'd3, 10'd0);
        collect();
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL horner_timeout: done_evb missing, expected within bound"); end
        n_checks++;
        if (obs_res.size() !== 3) begin n_fail++; $display("FAIL horner_count: got %0d expected 3", obs_res.size()); end
        for (int i = 0; i < 3 && i < obs_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== exp_r[i] || obs_st[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL horner_pt%0d: got %0d/%0d expected %0d/0", i, obs_res[i], obs_st[i], exp_r[i]);
            end
        end
        n_checks++;
        if (evb_addr !== 10'd3) begin n_fail++; $display("FAIL horner_addr_upd: got %0d expected 3", evb_addr); end
    endtask

    task automatic test_b_zero();
        start_instr(3'd0, 5'd0, 10'd7);
        collect();
        n_checks++;
        if (evb_lat !== 2) begin n_fail++; $display("FAIL bzero_latency: got %0d expected 2", evb_lat); end
        n_checks++;
        if (obs_res.size() !== 0 || en_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bzero_activity: got %0d evp, enables %b expected 0, 0", obs_res.size(), en_seen);
        end
        n_checks++;
        if (evb_addr !== 10'd7) begin n_fail++; $display("FAIL bzero_addr_upd: got %0d expected 7", evb_addr); end
    endtask

    task automatic test_abort();
        bit found;
        bit stray;
        logic [31:0] exp_r [3];
        exp_r = '{32'd10, 32'd27, 32'd60};
        found = 1'b0;
        start_instr(3'd0, 5'd3, 10'd0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.done_evp) begin found = 1'b1; break; end
        end
        n_checks++;
        if (found !== 1'b1 || bus.result !== 32'd10) begin
            n_fail++; $display("FAIL abort_first_pt: got found %b result %0d expected 1, 10", found, bus.result);
        end
        repeat (3) @(negedge clk);
        rst_instr = 1'b1;
        @(negedge clk);
        rst_instr = 1'b0;
        n_checks++;
        if ({bus.done_evp, bus.done_evb, bus.en_rd_N, bus.en_rd_S, bus.en_rd_data} !== 5'b0
            || bus.result !== 32'd0 || bus.status !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_cleared: got result %0d status %0d expected 0, 0", bus.result, bus.status);
        end
        stray = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done_evb || bus.done_evp || bus.en_rd_N) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got activity %b expected 0", stray); end
        start_instr(3'd0, 5'd3, 10'd0);
        collect();
        n_checks++;
        if (tmo !== 1'b0 || obs_res.size() !== 3) begin
            n_fail++; $display("FAIL abort_restart: got %0d points, timeout %b expected 3, 0", obs_res.size(), tmo);
        end
        for (int i = 0; i < 3 && i < obs_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== exp_r[i]) begin
                n_fail++; $display("FAIL abort_restart_pt%0d: got %0d expected %0d", i, obs_res[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Immediately after done_evb: wrap of the updated address, degree > 10, N = 0 and N = 10.
        start_instr(3'd6, 5'd6, 10'd1020);
        collect();
        n_checks++;
        if (obs_res.size() !== 6 || evb_addr !== 10'd2) begin
            n_fail++; $display("FAIL wrap_addr_upd: got %0d points addr %0d expected 6, 2", obs_res.size(), evb_addr);
        end
        for (int i = 0; i < obs_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== 32'd0 || obs_st[i] !== 32'd1) begin
                n_fail++; $display("FAIL deg11_pt%0d: got %0d/%0d expected 0/1", i, obs_res[i], obs_st[i]);
            end
        end
        start_instr(3'd1, 5'd2, 10'd0);
        collect();
        n_checks++;
        if (obs_res.size() !== 2) begin n_fail++; $display("FAIL const_count: got %0d expected 2", obs_res.size()); end
        for (int i = 0; i < obs_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== 32'd42 || obs_st[i] !== 32'd0) begin
                n_fail++; $display("FAIL const_pt%0d: got %0d/%0d expected 42/0", i, obs_res[i], obs_st[i]);
            end
        end
        start_instr(3'd2, 5'd1, 10'd20);
        collect();
        n_checks++;
        if (obs_res.size() !== 1 || obs_res[0] !== 32'd2047 || obs_st[0] !== 32'd0 || evb_addr !== 10'd21) begin
            n_fail++; $display("FAIL deg10: got %0d points addr %0d expected 2047/0 and addr 21", obs_res.size(), evb_addr);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_st;
`ifdef EVB_OVERFLOW_DETECT_EN
        exp_st = 32'd2;
`else
        exp_st = 32'd0;
`endif
        start_instr(3'd3, 5'd1, 10'd10);
        collect();
        n_checks++;
        if (obs_res.size() !== 1 || obs_res[0] !== 32'd4294836225 || obs_st[0] !== 32'd0) begin
            n_fail++; $display("FAIL ovf_edge: got %0d points expected 1 point 4294836225/0", obs_res.size());
            if (obs_res.size() > 0) $display("FAIL ovf_edge_val: got %0d/%0d expected 4294836225/0", obs_res[0], obs_st[0]);
        end
        start_instr(3'd4, 5'd1, 10'd10);
        collect();
        n_checks++;
        if (obs_res.size() !== 1 || obs_res[0] !== 32'd4294705154 || obs_st[0] !== exp_st) begin
            n_fail++; $display("FAIL ovf_wrap: got %0d points expected 1 point 4294705154/%0d", obs_res.size(), exp_st);
            if (obs_res.size() > 0) $display("FAIL ovf_wrap_val: got %0d/%0d expected 4294705154/%0d", obs_res[0], obs_st[0], exp_st);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        rst_instr        = 1'b0;
        bus.start_evb    = 1'b0;
        bus.A            = '0;
        bus.b            = '0;
        bus.rd_addr_data = '0;
        for (int i = 0; i < 8; i++)    nmem[i] = 5'd31;
        for (int i = 0; i < 128; i++)  smem[i] = 16'd0;
        for (int i = 0; i < 1024; i++) dmem[i] = 16'd0;
        nmem[0] = 5'd3;  smem[0] = 16'd3; smem[1] = 16'd4; smem[2] = 16'd2; smem[3] = 16'd1;
        dmem[0] = 16'd1; dmem[1] = 16'd2; dmem[2] = 16'd3;
        nmem[1] = 5'd0;  smem[11] = 16'd42;
        nmem[2] = 5'd10;
        for (int j = 22; j <= 32; j++) smem[j] = 16'd1;
        dmem[20] = 16'd2;
        nmem[3] = 5'd1;  smem[33] = 16'd0; smem[34] = 16'd65535;
        nmem[4] = 5'd2;  smem[44] = 16'd0; smem[45] = 16'd0; smem[46] = 16'd2;
        dmem[10] = 16'd65535;
        nmem[6] = 5'd11;

        test_reset();
        test_undefined();
        test_horner();
        test_b_zero();
        test_abort();
        test_back_to_back();
        test_overflow();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
